// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
//   Bundles the two writeback request channels (ALU from EX, load data from
//   MEM), the register-file write port and the hazard-unit pending mask.
//
//   Signals
//     alu_valid / alu_ready / alu_reg / alu_data  ALU writeback channel
//     mem_valid / mem_ready / mem_reg / mem_data  load writeback channel
//     RegWrite / WriteReg / WriteData             register file write port
//     pending_mask                                registers with an
//                                                 un-retired write
//
//   Modports
//     slave  : the arbiter (consumes requests, drives the write port)
//     master : the pipeline side (issues requests, observes the write port)
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                 alu_valid;
    logic                 alu_ready;
    logic [ADDR_W-1:0]    alu_reg;
    logic [DATA_W-1:0]    alu_data;

    logic                 mem_valid;
    logic                 mem_ready;
    logic [ADDR_W-1:0]    mem_reg;
    logic [DATA_W-1:0]    mem_data;

    logic                 RegWrite;
    logic [ADDR_W-1:0]    WriteReg;
    logic [DATA_W-1:0]    WriteData;
    logic [2**ADDR_W-1:0] pending_mask;

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        output alu_ready, mem_ready,
        output RegWrite, WriteReg, WriteData, pending_mask
    );

    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        input  alu_ready, mem_ready,
        input  RegWrite, WriteReg, WriteData, pending_mask
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the register file's single write port between ALU results and
//   load data. Each source owns a one-entry holding register filled through a
//   valid/ready handshake. One held entry is granted per cycle and presented
//   on the registered write port on the following edge.
//
//   Priority: MEM (older instruction) wins by default. Every cycle the ALU
//   entry is held but loses, a starvation counter advances; once it reaches
//   STARVE_MAX the ALU entry is forced through once and the counter clears.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    regfile_wb_arbiter_if.slave: request channels, write port,
//            pending_mask for the hazard unit
//
//   Parameters
//     DATA_W      register data width
//     ADDR_W      register index width (index 0 is hard-wired zero)
//     STARVE_MAX  consecutive ALU losses before the ALU is forced to win
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int NREG  = 2**ADDR_W;
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] ZERO_REG  = '0;

    // IDLE      : no holding entry valid, nothing to grant
    // MEM_PRI   : normal arbitration, MEM ahead of ALU
    // ALU_FORCE : ALU has lost STARVE_MAX times in a row and wins next
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEM_PRI   = 2'd1,
        ALU_FORCE = 2'd2
    } arbState_t;

    // ---------------- state ----------------
    arbState_t          state;
    logic               holdAluValid;
    logic [ADDR_W-1:0]  holdAluReg;
    logic [DATA_W-1:0]  holdAluData;
    logic               holdMemValid;
    logic [ADDR_W-1:0]  holdMemReg;
    logic [DATA_W-1:0]  holdMemData;
    logic [CNT_W-1:0]   starveCnt;
    logic               regWriteQ;
    logic [ADDR_W-1:0]  writeRegQ;
    logic [DATA_W-1:0]  writeDataQ;

    // ---------------- combinational ----------------
    logic               grantAlu;
    logic               grantMem;
    logic               aluReady;
    logic               memReady;
    logic               aluAccept;
    logic               memAccept;

    arbState_t          stateNext;
    logic               holdAluValidNext;
    logic [ADDR_W-1:0]  holdAluRegNext;
    logic [DATA_W-1:0]  holdAluDataNext;
    logic               holdMemValidNext;
    logic [ADDR_W-1:0]  holdMemRegNext;
    logic [DATA_W-1:0]  holdMemDataNext;
    logic [CNT_W-1:0]   starveCntNext;
    logic               regWriteNext;
    logic [ADDR_W-1:0]  writeRegNext;
    logic [DATA_W-1:0]  writeDataNext;

    logic [NREG-1:0]    pendingMask;

    // Grant decode. ALU_FORCE is only ever entered with the ALU entry valid,
    // so a forced grant always has something to write.
    always_comb begin
        grantAlu = holdAluValid && ((state == ALU_FORCE) || !holdMemValid);
        grantMem = holdMemValid && !grantAlu;
    end

    // A holding register frees up in the same cycle it is granted, which is
    // what lets a source stream one entry per cycle when it keeps winning.
    assign aluReady  = !holdAluValid || grantAlu;
    assign memReady  = !holdMemValid || grantMem;
    assign aluAccept = bus.alu_valid && aluReady;
    assign memAccept = bus.mem_valid && memReady;

    always_comb begin
        // Holding registers: a new accept overwrites an entry granted this
        // cycle; otherwise a granted entry drops out.
        holdAluValidNext = holdAluValid;
        holdAluRegNext   = holdAluReg;
        holdAluDataNext  = holdAluData;
        if (aluAccept) begin
            holdAluValidNext = 1'b1;
            holdAluRegNext   = bus.alu_reg;
            holdAluDataNext  = bus.alu_data;
        end else if (grantAlu) begin
            holdAluValidNext = 1'b0;
        end

        holdMemValidNext = holdMemValid;
        holdMemRegNext   = holdMemReg;
        holdMemDataNext  = holdMemData;
        if (memAccept) begin
            holdMemValidNext = 1'b1;
            holdMemRegNext   = bus.mem_reg;
            holdMemDataNext  = bus.mem_data;
        end else if (grantMem) begin
            holdMemValidNext = 1'b0;
        end

        // Starvation counter: clears on any ALU grant, saturates on losses.
        starveCntNext = starveCnt;
        if (grantAlu) begin
            starveCntNext = '0;
        end else if (holdAluValid && grantMem && (starveCnt != STARVE_LIM)) begin
            starveCntNext = starveCnt + CNT_W'(1);
        end

        // State is computed from next-cycle holds and counter so that the
        // registered state directly selects the grant in the following cycle.
        if (!holdAluValidNext && !holdMemValidNext) begin
            stateNext = IDLE;
        end else if (holdAluValidNext && (starveCntNext == STARVE_LIM)) begin
            stateNext = ALU_FORCE;
        end else begin
            stateNext = MEM_PRI;
        end

        // Write port. Index and data keep their last values when idle; a grant
        // to register 0 retires the entry without touching the port.
        regWriteNext  = 1'b0;
        writeRegNext  = writeRegQ;
        writeDataNext = writeDataQ;
        if (grantMem && (holdMemReg != ZERO_REG)) begin
            regWriteNext  = 1'b1;
            writeRegNext  = holdMemReg;
            writeDataNext = holdMemData;
        end else if (grantAlu && (holdAluReg != ZERO_REG)) begin
            regWriteNext  = 1'b1;
            writeRegNext  = holdAluReg;
            writeDataNext = holdAluData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            holdAluValid <= 1'b0;
            holdAluReg   <= '0;
            holdAluData  <= '0;
            holdMemValid <= 1'b0;
            holdMemReg   <= '0;
            holdMemData  <= '0;
            starveCnt    <= '0;
            regWriteQ    <= 1'b0;
            writeRegQ    <= '0;
            writeDataQ   <= '0;
        end else begin
            state        <= stateNext;
            holdAluValid <= holdAluValidNext;
            holdAluReg   <= holdAluRegNext;
            holdAluData  <= holdAluDataNext;
            holdMemValid <= holdMemValidNext;
            holdMemReg   <= holdMemRegNext;
            holdMemData  <= holdMemDataNext;
            starveCnt    <= starveCntNext;
            regWriteQ    <= regWriteNext;
            writeRegQ    <= writeRegNext;
            writeDataQ   <= writeDataNext;
        end
    end

    // Pending mask: a register is pending while its write sits in either
    // holding register or is on the write port this cycle. Register 0 never
    // has a real write, so its bit is tied low.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : gPend
            if (gi == 0) begin : gZero
                assign pendingMask[gi] = 1'b0;
            end else begin : gReg
                assign pendingMask[gi] =
                      (holdMemValid && (holdMemReg == ADDR_W'(gi)))
                    | (holdAluValid && (holdAluReg == ADDR_W'(gi)))
                    | (regWriteQ    && (writeRegQ  == ADDR_W'(gi)));
            end
        end
    endgenerate

    assign bus.alu_ready    = aluReady;
    assign bus.mem_ready    = memReady;
    assign bus.RegWrite     = regWriteQ;
    assign bus.WriteReg     = writeRegQ;
    assign bus.WriteData    = writeDataQ;
    assign bus.pending_mask = pendingMask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Directed bench for regfile_wb_arbiter. Expected register writes are
//   queued as stimulus is driven; a negedge monitor pops and compares every
//   write the DUT produces and keeps a shadow register file.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk;
    logic rst_n;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t         expQ[$];
    logic [31:0] rfModel [32];
    int          testCount = 0;
    int          failCount = 0;
    int          writeCount = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        wr_t w;
        w.r = r;
        w.d = d;
        expQ.push_back(w);
    endtask

    // Write monitor: every RegWrite pulse must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            check("pend_bit0", 64'(bus.pending_mask[0]), 64'd0);
            if (bus.RegWrite === 1'b1) begin
                wr_t w;
                writeCount++;
                if (expQ.size() == 0) begin
                    check("unexpected_write_reg", 64'(bus.WriteReg), 64'hFFFF);
                end else begin
                    w = expQ.pop_front();
                    check("write_reg", 64'(bus.WriteReg), 64'(w.r));
                    check("write_data", 64'(bus.WriteData), 64'(w.d));
                end
                $display("[TB] write r%0d = %0h", bus.WriteReg, bus.WriteData);
                rfModel[bus.WriteReg] = bus.WriteData;
            end
        end
    end

    initial begin
        int sent;
        int stalls;
        int stallAt;
        int wcSnap;
        logic [31:0] data;
        logic rdy;

        for (int i = 0; i < 32; i++) rfModel[i] = '0;
        rst_n = 1'b0;
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;

        // ---------------- reset state ----------------
        step(); step();
        check("rst_regwrite", 64'(bus.RegWrite), 64'd0);
        check("rst_writereg", 64'(bus.WriteReg), 64'd0);
        check("rst_writedata", 64'(bus.WriteData), 64'd0);
        check("rst_pending", 64'(bus.pending_mask), 64'd0);
        check("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("rst_mem_ready", 64'(bus.mem_ready), 64'd1);
        rst_n = 1'b1;
        step();

        // ---------------- 1: single ALU write, latency ----------------
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'd37;
        pushExp(5'd5, 32'd37);
        step();                                   // accept edge
        bus.alu_valid = 1'b0;
        check("t1_pend_held", 64'(bus.pending_mask), 64'h20);
        check("t1_no_write_yet", 64'(bus.RegWrite), 64'd0);
        step();                                   // second edge: write visible
        check("t1_regwrite", 64'(bus.RegWrite), 64'd1);
        check("t1_writereg", 64'(bus.WriteReg), 64'd5);
        check("t1_writedata", 64'(bus.WriteData), 64'd37);
        check("t1_pend_driving", 64'(bus.pending_mask), 64'h20);
        step();
        check("t1_regwrite_one_cycle", 64'(bus.RegWrite), 64'd0);
        check("t1_pend_clear", 64'(bus.pending_mask), 64'd0);
        check("t1_writereg_hold", 64'(bus.WriteReg), 64'd5);
        check("t1_writedata_hold", 64'(bus.WriteData), 64'd37);

        // ---------------- 2: both valid, MEM first ----------------
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd3; bus.mem_data = 32'd7;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd4; bus.alu_data = 32'd9;
        pushExp(5'd3, 32'd7);
        pushExp(5'd4, 32'd9);
        step();
        bus.mem_valid = 1'b0; bus.alu_valid = 1'b0;
        check("t2_alu_ready_low", 64'(bus.alu_ready), 64'd0);
        check("t2_mem_ready", 64'(bus.mem_ready), 64'd1);
        step();
        check("t2_alu_ready_back", 64'(bus.alu_ready), 64'd1);
        check("t2_first_reg", 64'(bus.WriteReg), 64'd3);
        step();
        check("t2_second_reg", 64'(bus.WriteReg), 64'd4);
        step();
        check("t2_drained", 64'(expQ.size()), 64'd0);

        // ---------------- 3: ALU starvation limit ----------------
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd10; bus.mem_data = 32'd100;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd6;  bus.alu_data = 32'd66;
        pushExp(5'd10, 32'd100);
        pushExp(5'd10, 32'd101);
        pushExp(5'd10, 32'd102);
        pushExp(5'd6,  32'd66);
        pushExp(5'd10, 32'd103);
        pushExp(5'd10, 32'd104);
        step();
        bus.alu_valid = 1'b0;
        sent = 1; data = 32'd101; stalls = 0; stallAt = -1;
        for (int c = 0; c < 20 && sent < 5; c++) begin
            bus.mem_data = data;
            rdy = bus.mem_ready;
            if (!rdy) begin
                stalls++;
                if (stallAt < 0) stallAt = c;
            end
            step();
            if (rdy) begin
                sent++;
                data++;
            end
        end
        bus.mem_valid = 1'b0;
        check("t3_all_sent", 64'(sent), 64'd5);
        check("t3_stall_count", 64'(stalls), 64'd1);
        check("t3_stall_cycle", 64'(stallAt), 64'd3);
        step(); step(); step();
        check("t3_drained", 64'(expQ.size()), 64'd0);
        check("t3_r6", 64'(rfModel[6]), 64'd66);

        // ---------------- 4: write to register 0 ----------------
        wcSnap = writeCount;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd0; bus.alu_data = 32'hFFFF_FFFF;
        step();
        bus.alu_valid = 1'b0;
        check("t4_pend_zero", 64'(bus.pending_mask), 64'd0);
        check("t4_alu_ready", 64'(bus.alu_ready), 64'd1);
        step();
        check("t4_no_regwrite", 64'(bus.RegWrite), 64'd0);
        check("t4_pend_zero2", 64'(bus.pending_mask), 64'd0);
        step();
        check("t4_no_write_seen", 64'(writeCount), 64'(wcSnap));

        // ---------------- 5: same register from both ----------------
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd8; bus.mem_data = 32'd11;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd8; bus.alu_data = 32'd22;
        pushExp(5'd8, 32'd11);
        pushExp(5'd8, 32'd22);
        step();
        bus.mem_valid = 1'b0; bus.alu_valid = 1'b0;
        check("t5_pend8", 64'(bus.pending_mask), 64'h100);
        step(); step(); step();
        check("t5_r8_final", 64'(rfModel[8]), 64'd22);
        check("t5_drained", 64'(expQ.size()), 64'd0);

        // ---------------- 6: reset mid-operation ----------------
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd12; bus.mem_data = 32'd1;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd13; bus.alu_data = 32'd2;
        step();
        bus.alu_valid = 1'b0;
        bus.mem_reg = 5'd14; bus.mem_data = 32'd3;
        step();
        bus.mem_valid = 1'b0;
        check("t6_regwrite_before", 64'(bus.RegWrite), 64'd1);
        check("t6_writereg_before", 64'(bus.WriteReg), 64'd12);
        check("t6_pend_before", 64'(bus.pending_mask), 64'h7000);
        wcSnap = writeCount;
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_regwrite", 64'(bus.RegWrite), 64'd0);
        check("t6_rst_pending", 64'(bus.pending_mask), 64'd0);
        check("t6_rst_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("t6_rst_mem_ready", 64'(bus.mem_ready), 64'd1);
        check("t6_rst_writereg", 64'(bus.WriteReg), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step(); step(); step(); step();
        check("t6_no_write_after", 64'(writeCount), 64'(wcSnap));
        check("t6_pend_after", 64'(bus.pending_mask), 64'd0);
        check("final_queue_empty", 64'(expQ.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
